// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command queue: FSM encoding and control-word layout.
package lcd_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned START_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_CLR   = 3'd5
  } lcd_state_e;

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Register-based command FIFO with registered status flags and synchronous flush.
module lcd_cmd_fifo
  import lcd_pkg::*;
#(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] head_c,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count_d;
  logic              push_ok;
  logic              pop_ok;

  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign head_c  = mem[rd_ptr];

  always_comb begin
    count_d = count;
    if (flush)
      count_d = '0;
    else if (push_ok && !pop_ok)
      count_d = count + CW'(1);
    else if (pop_ok && !push_ok)
      count_d = count - CW'(1);
  end

  // Flags are registered from the next occupancy so they line up with count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      count <= count_d;
      full  <= (count_d == CW'(DEPTH));
      empty <= (count_d == '0);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + AW'(1);
        if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      mem <= '{default: '0};
    else if (push_ok)
      mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/lcd_cmd_queue.sv
// Command queue that issues FIFO'd control words to the LCD controller with a start-bit
// handshake, a per-command watchdog and a two-cycle controller clear.
module lcd_cmd_queue
  import lcd_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TMO_W = 24
) (
  input  logic                       clk,
  input  logic                       RSTn,
  input  logic                       cmd_wr,
  input  logic [WORD_W-1:0]          cmd_data,
  input  logic                       flush,
  input  logic                       LCD_RUN_FINISH,
  input  logic                       LCD_Flag,
  output logic [WORD_W-1:0]          LCD_REG,
  output logic                       rstn_LCD_en,
  output logic                       cmd_full,
  output logic                       cmd_empty,
  output logic [$clog2(DEPTH):0]     cmd_count,
  output logic                       busy,
  output logic                       tmo_err
);

  lcd_state_e        state_q, state_d;
  logic [WORD_W-1:0] reg_d;
  logic [WORD_W-1:0] head_c;
  logic [TMO_W-1:0]  wdog_q, wdog_d, wdog_inc;
  logic              clr_q, clr_d;
  logic              tmo_d;
  logic              pop;
  logic              timed;

  lcd_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (RSTn),
    .push   (cmd_wr),
    .pop    (pop),
    .flush  (flush),
    .wdata  (cmd_data),
    .head_c (head_c),
    .full   (cmd_full),
    .empty  (cmd_empty),
    .count  (cmd_count)
  );

  // Next state, next control word, watchdog and clear-window bookkeeping.
  always_comb begin
    state_d  = state_q;
    reg_d    = LCD_REG;
    wdog_d   = wdog_q;
    clr_d    = clr_q;
    tmo_d    = tmo_err;
    pop      = 1'b0;
    wdog_inc = wdog_q + TMO_W'(1);
    timed    = state_q inside {ST_START, ST_RUN, ST_DRAIN};

    if (flush) begin
      state_d = ST_CLR;
      clr_d   = 1'b0;
      tmo_d   = 1'b0;
      reg_d   = '0;
    end else if (timed && (wdog_inc == '1)) begin
      state_d = ST_CLR;
      clr_d   = 1'b0;
      tmo_d   = 1'b1;
      reg_d   = '0;
    end else begin
      if (timed) wdog_d = wdog_inc;
      unique case (state_q)
        ST_IDLE: begin
          if (!cmd_empty) begin
            pop              = 1'b1;
            reg_d            = head_c;
            reg_d[START_BIT] = 1'b0;
            state_d          = ST_LOAD;
          end
        end
        ST_LOAD: begin
          reg_d[START_BIT] = 1'b1;
          wdog_d           = '0;
          state_d          = ST_START;
        end
        ST_START: begin
          if (LCD_Flag) begin
            reg_d[START_BIT] = 1'b0;
            state_d          = ST_RUN;
          end
        end
        ST_RUN: begin
          if (LCD_RUN_FINISH) state_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!LCD_Flag && !LCD_RUN_FINISH) state_d = ST_IDLE;
        end
        ST_CLR: begin
          if (clr_q) state_d = ST_IDLE;
          else       clr_d   = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so no input reaches them combinationally.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= ST_IDLE;
      LCD_REG     <= '0;
      wdog_q      <= '0;
      clr_q       <= 1'b0;
      tmo_err     <= 1'b0;
      busy        <= 1'b0;
      rstn_LCD_en <= 1'b0;
    end else begin
      state_q     <= state_d;
      LCD_REG     <= reg_d;
      wdog_q      <= wdog_d;
      clr_q       <= clr_d;
      tmo_err     <= tmo_d;
      busy        <= (state_d != ST_IDLE);
      rstn_LCD_en <= (state_d != ST_CLR);
    end
  end

endmodule

// File: tb/tb_lcd_cmd_queue.sv
// Self-checking bench for lcd_cmd_queue: directed scenarios plus random traffic against a queue-based reference model.
module tb_lcd_cmd_queue;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned TMO_W   = 4;
  localparam int          TMO_LIM = (1 << TMO_W) - 1;

  localparam int PH_IDLE  = 0;
  localparam int PH_LOAD  = 1;
  localparam int PH_START = 2;
  localparam int PH_RUN   = 3;
  localparam int PH_DRAIN = 4;
  localparam int PH_CLR   = 5;

  logic        clk = 1'b0;
  logic        RSTn;
  logic        cmd_wr;
  logic [31:0] cmd_data;
  logic        flush;
  logic        LCD_RUN_FINISH;
  logic        LCD_Flag;
  logic [31:0] LCD_REG;
  logic        rstn_LCD_en;
  logic        cmd_full;
  logic        cmd_empty;
  logic [3:0]  cmd_count;
  logic        busy;
  logic        tmo_err;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  logic [31:0] m_q[$];
  int          m_phase;
  int          m_age;
  int          m_clr;
  logic [31:0] m_reg;
  bit          m_tmo;
  bit          m_en;

  logic [31:0] iss[$];
  logic        prev_start;

  lcd_cmd_queue #(.DEPTH(DEPTH), .TMO_W(TMO_W)) dut (
    .clk            (clk),
    .RSTn           (RSTn),
    .cmd_wr         (cmd_wr),
    .cmd_data       (cmd_data),
    .flush          (flush),
    .LCD_RUN_FINISH (LCD_RUN_FINISH),
    .LCD_Flag       (LCD_Flag),
    .LCD_REG        (LCD_REG),
    .rstn_LCD_en    (rstn_LCD_en),
    .cmd_full       (cmd_full),
    .cmd_empty      (cmd_empty),
    .cmd_count      (cmd_count),
    .busy           (busy),
    .tmo_err        (tmo_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_phase = PH_IDLE;
    m_age   = 0;
    m_clr   = 0;
    m_reg   = '0;
    m_tmo   = 0;
    m_en    = 0;
  endtask

  // One clock edge of the queue's documented behaviour.
  task automatic model_step(input logic wr, input logic [31:0] d, input logic fl,
                            input logic fin, input logic flg);
    int sz;
    sz = m_q.size();
    if (fl) begin
      m_q.delete();
      m_phase = PH_CLR;
      m_clr   = 2;
      m_tmo   = 0;
      m_reg   = '0;
    end else begin
      if (wr && sz < DEPTH) m_q.push_back(d);
      if ((m_phase == PH_START || m_phase == PH_RUN || m_phase == PH_DRAIN) &&
          (m_age + 1 == TMO_LIM)) begin
        m_phase = PH_CLR;
        m_clr   = 2;
        m_tmo   = 1;
        m_reg   = '0;
      end else begin
        case (m_phase)
          PH_IDLE: if (sz > 0) begin
            m_reg    = m_q.pop_front();
            m_reg[0] = 1'b0;
            m_phase  = PH_LOAD;
          end
          PH_LOAD: begin
            m_reg[0] = 1'b1;
            m_age    = 0;
            m_phase  = PH_START;
          end
          PH_START: begin
            m_age++;
            if (flg) begin
              m_reg[0] = 1'b0;
              m_phase  = PH_RUN;
            end
          end
          PH_RUN: begin
            m_age++;
            if (fin) m_phase = PH_DRAIN;
          end
          PH_DRAIN: begin
            m_age++;
            if (!flg && !fin) m_phase = PH_IDLE;
          end
          default: begin
            m_clr--;
            if (m_clr == 0) m_phase = PH_IDLE;
          end
        endcase
      end
    end
    m_en = (m_phase != PH_CLR);
  endtask

  task automatic compare_all();
    check("lcd_reg",   LCD_REG,            m_reg);
    check("en",        32'(rstn_LCD_en),   32'(m_en));
    check("busy",      32'(busy),          32'(m_phase != PH_IDLE));
    check("tmo_err",   32'(tmo_err),       32'(m_tmo));
    check("count",     32'(cmd_count),     32'(m_q.size()));
    check("full",      32'(cmd_full),      32'(m_q.size() == DEPTH));
    check("empty",     32'(cmd_empty),     32'(m_q.size() == 0));
  endtask

  task automatic cycle(input logic wr, input logic [31:0] d, input logic fl,
                       input logic fin, input logic flg);
    @(negedge clk);
    cmd_wr = wr; cmd_data = d; flush = fl; LCD_RUN_FINISH = fin; LCD_Flag = flg;
    @(posedge clk);
    model_step(wr, d, fl, fin, flg);
    #1;
    compare_all();
    if (LCD_REG[0] && !prev_start) iss.push_back(LCD_REG);
    prev_start = LCD_REG[0];
  endtask

  task automatic idle_inputs();
    cmd_wr = 0; cmd_data = '0; flush = 0; LCD_RUN_FINISH = 0; LCD_Flag = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    #2 RSTn = 1'b0;
    model_reset();
    prev_start = 1'b0;
    #1 compare_all();
    @(posedge clk);
    @(posedge clk);
    #2 RSTn = 1'b1;
  endtask

  // Controller that cycles Flag/Finish in a fixed 4-cycle pattern.
  task automatic ctl_cycle(input int i, input logic wr, input logic [31:0] d);
    int p;
    p = i % 4;
    cycle(wr, d, 1'b0, (p == 1), (p < 2));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w[9];
    logic [31:0] acc[$];
    logic [31:0] x, y, a;
    int t, pushed, guard;

    RSTn = 1'b1;
    idle_inputs();

    // reset values
    do_reset();

    // single command walk-through
    cycle(1, 32'h0000_00A4, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    check("a4_load", LCD_REG, 32'h0000_00A4);
    cycle(0, 0, 0, 0, 0);
    check("a4_start", LCD_REG, 32'h0000_00A5);
    cycle(0, 0, 0, 0, 0);
    check("a4_hold", LCD_REG, 32'h0000_00A5);
    cycle(0, 0, 0, 0, 1);
    check("a4_run", LCD_REG, 32'h0000_00A4);
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 1);
    check("a4_drain_busy", 32'(busy), 32'd1);
    cycle(0, 0, 0, 0, 0);
    check("a4_idle_busy", 32'(busy), 32'd0);

    // overflow while stalled, then ordered release
    do_reset();
    iss.delete();
    x = $urandom();
    cycle(1, x, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      w[i] = $urandom();
      cycle(1, w[i], 0, 0, 0);
    end
    check("ovf_count", 32'(cmd_count), 32'd8);
    check("ovf_full", 32'(cmd_full), 32'd1);
    for (int i = 0; i < 120; i++) ctl_cycle(i, 0, 0);
    check("ovf_issued", 32'(iss.size()), 32'd9);
    if (iss.size() == 9) begin
      check("ovf_first", iss[0], x | 32'd1);
      for (int i = 0; i < 8; i++) check("ovf_order", iss[i+1], w[i] | 32'd1);
    end

    // push and pop in the same cycle at count 3
    do_reset();
    a = $urandom();
    cycle(1, $urandom(), 0, 0, 0);
    cycle(1, a, 0, 0, 0);
    cycle(1, $urandom(), 0, 0, 0);
    cycle(1, $urandom(), 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 0);
    check("pp_pre", 32'(cmd_count), 32'd3);
    cycle(1, $urandom(), 0, 0, 0);
    check("pp_count", 32'(cmd_count), 32'd3);
    check("pp_load", LCD_REG, a & 32'hFFFF_FFFE);

    // pointer wrap over 20 commands
    do_reset();
    iss.delete();
    acc.delete();
    pushed = 0;
    for (int i = 0; i < 400 && iss.size() < 20; i++) begin
      if (pushed < 20 && m_q.size() < DEPTH) begin
        x = $urandom();
        acc.push_back(x | 32'd1);
        pushed++;
        ctl_cycle(i, 1, x);
      end else begin
        ctl_cycle(i, 0, 0);
      end
    end
    check("wrap_issued", 32'(iss.size()), 32'd20);
    if (iss.size() == 20)
      for (int i = 0; i < 20; i++) check("wrap_order", iss[i], acc[i]);

    // watchdog expiry
    do_reset();
    x = $urandom();
    y = $urandom();
    cycle(1, x, 0, 0, 0);
    cycle(1, y, 0, 0, 0);
    guard = 0;
    while (!LCD_REG[0] && guard < 10) begin
      cycle(0, 0, 0, 0, 0);
      guard++;
    end
    check("tmo_start", 32'(LCD_REG[0]), 32'd1);
    t = 0;
    while (!tmo_err && t < 40) begin
      cycle(0, 0, 0, 0, 1);
      t++;
    end
    check("tmo_latency", 32'(t), 32'd15);
    check("tmo_en0", 32'(rstn_LCD_en), 32'd0);
    cycle(0, 0, 0, 0, 0);
    check("tmo_en1", 32'(rstn_LCD_en), 32'd0);
    cycle(0, 0, 0, 0, 0);
    check("tmo_en_back", 32'(rstn_LCD_en), 32'd1);
    check("tmo_sticky", 32'(tmo_err), 32'd1);
    guard = 0;
    while (!LCD_REG[0] && guard < 10) begin
      cycle(0, 0, 0, 0, 0);
      guard++;
    end
    check("tmo_next_cmd", LCD_REG, y | 32'd1);

    // flush in RUN with three queued
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, $urandom(), 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    check("fl_pre", 32'(cmd_count), 32'd3);
    cycle(1, $urandom(), 1, 0, 0);
    check("fl_count", 32'(cmd_count), 32'd0);
    check("fl_en0", 32'(rstn_LCD_en), 32'd0);
    check("fl_reg", LCD_REG, 32'd0);
    cycle(0, 0, 0, 0, 0);
    check("fl_en1", 32'(rstn_LCD_en), 32'd0);
    cycle(0, 0, 0, 0, 0);
    check("fl_en_back", 32'(rstn_LCD_en), 32'd1);
    check("fl_busy", 32'(busy), 32'd0);
    check("fl_reg_idle", LCD_REG, 32'd0);

    // asynchronous reset in RUN
    do_reset();
    cycle(1, 32'h0000_00A4, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    check("ar_busy_pre", 32'(busy), 32'd1);
    #2 RSTn = 1'b0;
    #1;
    check("ar_reg", LCD_REG, 32'd0);
    check("ar_en", 32'(rstn_LCD_en), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_empty", 32'(cmd_empty), 32'd1);
    check("ar_count", 32'(cmd_count), 32'd0);
    model_reset();
    prev_start = 1'b0;
    idle_inputs();
    @(posedge clk);
    #2 RSTn = 1'b1;
    cycle(1, 32'h1234_5678, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    check("ar_resume", LCD_REG, 32'h1234_5678);
    cycle(0, 0, 0, 0, 0);
    check("ar_resume_start", LCD_REG, 32'h1234_5679);

    // random traffic
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 9) < 4), $urandom(), ($urandom_range(0, 63) == 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
